// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed driver for a 4-digit common-anode 7-segment
// display. Each digit stays lit for SCAN_DIV clk cycles; digits are scanned
// an[0] -> an[3] and the scan repeats.
//
// Ports:
//   clk      system clock
//   rstn     synchronous active-low reset (display dark while low)
//   digit0-3 5-bit character codes, digit0 = rightmost (an[0])
//   decplace index of the digit whose decimal point is lit
//   seg      active-low segments, seg[0]=a .. seg[6]=g, seg[7]=dp
//   an       active-low one-hot digit enable
//   dp       active-low decimal point (mirrors seg[7])
//
// Build option:
//   SEVENSEG_DP_EN  when defined, the decimal point follows decplace;
//                   otherwise decplace is ignored and dp/seg[7] stay at 1.
module sevenseg_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] digit0,
  input  logic [4:0] digit1,
  input  logic [4:0] digit2,
  input  logic [4:0] digit3,
  input  logic [1:0] decplace,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [4:0]       char_code;
  logic [6:0]       pattern;
  logic [6:0]       seg_lo;

  // Dwell counter and digit index
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Select the active digit's character code
  always_comb begin
    char_code = digit0;
    case (idx)
      2'd0:    char_code = digit0;
      2'd1:    char_code = digit1;
      2'd2:    char_code = digit2;
      default: char_code = digit3;
    endcase
  end

  // Character decode to active-high gfedcba
  always_comb begin
    pattern = 7'h00;
    case (char_code)
      5'h00: pattern = 7'h3F;
      5'h01: pattern = 7'h06;
      5'h02: pattern = 7'h5B;
      5'h03: pattern = 7'h4F;
      5'h04: pattern = 7'h66;
      5'h05: pattern = 7'h6D;
      5'h06: pattern = 7'h7D;
      5'h07: pattern = 7'h07;
      5'h08: pattern = 7'h7F;
      5'h09: pattern = 7'h6F;
      5'h0A: pattern = 7'h77;
      5'h0B: pattern = 7'h7C;
      5'h0C: pattern = 7'h39;
      5'h0D: pattern = 7'h5E;
      5'h0E: pattern = 7'h79;
      5'h0F: pattern = 7'h71;
      5'h10: pattern = 7'h00;
      5'h11: pattern = 7'h5C;
      5'h12: pattern = 7'h78;
      5'h13: pattern = 7'h3D;
      5'h14: pattern = 7'h73;
      5'h15: pattern = 7'h76;
      5'h16: pattern = 7'h6D;
      5'h17: pattern = 7'h50;
      5'h18: pattern = 7'h40;
      5'h19: pattern = 7'h38;
      5'h1A: pattern = 7'h54;
      5'h1B: pattern = 7'h3E;
      default: pattern = 7'h00;
    endcase
  end

  // Output registers: one cycle behind the index they reflect
  always_ff @(posedge clk) begin
    if (!rstn) begin
      an     <= 4'b1111;
      seg_lo <= 7'h7F;
    end else begin
      an     <= ~(4'b0001 << idx);
      seg_lo <= ~pattern;
    end
  end

`ifdef SEVENSEG_DP_EN
  // Decimal point lit on the digit selected by decplace
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dp <= 1'b1;
    end else begin
      dp <= (idx != decplace);
    end
  end
`else
  logic unused_decplace;
  assign unused_decplace = ^decplace;
  assign dp = 1'b1;
`endif

  assign seg = {dp, seg_lo};

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan with SCAN_DIV=4: reset, scan timing,
// character decode, decimal point and mid-scan reset, using directed vectors.
module tb_sevenseg_scan;

  logic       clk;
  logic       rstn;
  logic [4:0] digit0;
  logic [4:0] digit1;
  logic [4:0] digit2;
  logic [4:0] digit3;
  logic [1:0] decplace;
  logic [7:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_checks;
  int n_fail;

  // Inverted (active-low) hex decode, hand-computed from the gfedcba table
  localparam logic [6:0] HEX_EXP [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  // Expected seg[6:0] for digits S, G, H, blank
  localparam logic [6:0] TXT_EXP [4] = '{7'h12, 7'h42, 7'h09, 7'h7F};
  localparam logic [3:0] AN_EXP  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  sevenseg_scan #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .decplace (decplace),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, "_an"}, 32'(an), 32'(4'b1111));
    check_eq({tag, "_seg"}, 32'(seg), 32'(8'hFF));
    check_eq({tag, "_dp"}, 32'(dp), 32'(1'b1));
  endtask

  // Sample n cycles of scanning starting right after reset release
  task automatic scan_check(input int n);
    int k;
    logic exp_dp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k = (i / 4) % 4;
`ifdef SEVENSEG_DP_EN
      exp_dp = (k == 2) ? 1'b0 : 1'b1;
`else
      exp_dp = 1'b1;
`endif
      check_eq($sformatf("scan%0d_an", i), 32'(an), 32'(AN_EXP[k]));
      check_eq($sformatf("scan%0d_seg", i), 32'(seg[6:0]), 32'(TXT_EXP[k]));
      check_eq($sformatf("scan%0d_dp", i), 32'(dp), 32'(exp_dp));
      check_eq($sformatf("scan%0d_seg7", i), 32'(seg[7]), 32'(exp_dp));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk      = 1'b0;
    rstn     = 1'b0;
    digit0   = 5'h16;
    digit1   = 5'h13;
    digit2   = 5'h15;
    digit3   = 5'h10;
    decplace = 2'd2;

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      check_dark("rst");
    end

    // Release and scan; stop on the second cycle of an=1011
    rstn = 1'b1;
    scan_check(26);

    // Mid-scan reset while an=1011
    rstn = 1'b0;
    @(negedge clk);
    check_dark("midrst1");
    @(negedge clk);
    check_dark("midrst2");
    rstn = 1'b1;
    scan_check(8);

    // Hex sweep on digit0: first output after release shows digit0
    for (int c = 0; c < 16; c++) begin
      rstn   = 1'b0;
      digit0 = 5'(c);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_eq($sformatf("hex%0h_an", c), 32'(an), 32'(4'b1110));
      check_eq($sformatf("hex%0h_seg", c), 32'(seg[6:0]), 32'(HEX_EXP[c]));
    end

    // Unused code decodes as blank
    rstn   = 1'b0;
    digit0 = 5'h1F;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("code1f_seg", 32'(seg[6:0]), 32'(7'h7F));

    // Input change mid-dwell appears next cycle, no latching
    digit0 = 5'h08;
    @(negedge clk);
    check_eq("live_an", 32'(an), 32'(4'b1110));
    check_eq("live_seg", 32'(seg[6:0]), 32'(7'h00));
    digit0 = 5'h01;
    @(negedge clk);
    check_eq("live2_seg", 32'(seg[6:0]), 32'(7'h79));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
